// File: rtl/imm_extend_if.sv
// Request/result bus for the immediate-extend pipeline.
// The master issues requests and accepts results; the slave is the pipeline.
interface imm_extend_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_mode;
    logic [IMM_W-1:0]  in_imm;
    logic [JIDX_W-1:0] in_jidx;
    logic [DATA_W-1:0] in_npc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              out_wrap;

    modport master (
        output in_valid, in_mode, in_imm, in_jidx, in_npc, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_wrap
    );

    modport slave (
        input  in_valid, in_mode, in_imm, in_jidx, in_npc, out_ready,
        output in_ready, out_valid, out_data, out_err, out_wrap
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extension / branch and jump target pipeline with valid/ready flow control.
// Define IMM_EXTEND_WRAP_DET_EN to flag BRANCH targets that wrap the address space on out_wrap.
module imm_extend_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26,
    parameter int SHIFT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    imm_extend_if.slave bus
);
    localparam logic [2:0] M_SEXT   = 3'd0;
    localparam logic [2:0] M_ZEXT   = 3'd1;
    localparam logic [2:0] M_UPPER  = 3'd2;
    localparam logic [2:0] M_BRANCH = 3'd3;
    localparam logic [2:0] M_JUMP   = 3'd4;
    // npc bits kept by JUMP; the rest come from the shifted jump index.
    localparam logic [DATA_W-1:0] HI_MASK = ~((DATA_W'(1) << (JIDX_W + SHIFT)) - DATA_W'(1));

    function automatic logic signed [DATA_W-1:0] extend_imm(
        input logic [2:0]        mode,
        input logic [IMM_W-1:0]  imm,
        input logic [JIDX_W-1:0] jidx
    );
        logic signed [DATA_W-1:0] se;
        se = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        case (mode)
            M_SEXT:   extend_imm = se;
            M_ZEXT:   extend_imm = {{(DATA_W-IMM_W){1'b0}}, imm};
            M_UPPER:  extend_imm = {imm, {(DATA_W-IMM_W){1'b0}}};
            M_BRANCH: extend_imm = se <<< SHIFT;
            M_JUMP:   extend_imm = {{(DATA_W-JIDX_W-SHIFT){1'b0}}, jidx, {SHIFT{1'b0}}};
            default:  extend_imm = '0;
        endcase
    endfunction

    logic                     vld_p1, vld_p2, adv_p1, accept;
    logic [2:0]               mode_p1;
    logic [DATA_W-1:0]        npc_p1;
    logic signed [DATA_W-1:0] opnd_p1;
    logic [DATA_W-1:0]        sum_p1, res_p1;
    logic                     err_p1, wrap_p1, brwrap_p1;
    logic [DATA_W-1:0]        data_p2;
    logic                     err_p2, wrap_p2;

    assign adv_p1       = !vld_p2 || bus.out_ready;
    assign bus.in_ready = !vld_p1 || adv_p1;
    assign accept       = bus.in_valid && bus.in_ready;

    // Stage 1: capture mode, npc and the extended/shifted operand
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (bus.in_ready) begin
            vld_p1 <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mode_p1 <= bus.in_mode;
            npc_p1  <= bus.in_npc;
            opnd_p1 <= extend_imm(bus.in_mode, bus.in_imm, bus.in_jidx);
        end
    end

`ifdef IMM_EXTEND_WRAP_DET_EN
    logic [DATA_W:0] sum_ext_p1;
    assign sum_ext_p1 = {1'b0, npc_p1} + {1'b0, $unsigned(opnd_p1)};
    assign sum_p1     = sum_ext_p1[DATA_W-1:0];
    // Negative offsets wrap when the add produces no carry (a borrow), positive ones when it does.
    assign brwrap_p1  = opnd_p1[DATA_W-1] ? !sum_ext_p1[DATA_W] : sum_ext_p1[DATA_W];
`else
    assign sum_p1     = npc_p1 + $unsigned(opnd_p1);
    assign brwrap_p1  = 1'b0;
`endif

    always_comb begin
        res_p1  = '0;
        err_p1  = 1'b0;
        wrap_p1 = 1'b0;
        case (mode_p1)
            M_SEXT, M_ZEXT, M_UPPER: res_p1 = $unsigned(opnd_p1);
            M_BRANCH: begin
                res_p1  = sum_p1;
                wrap_p1 = brwrap_p1;
            end
            M_JUMP:   res_p1 = (npc_p1 & HI_MASK) | $unsigned(opnd_p1);
            default:  err_p1 = 1'b1;
        endcase
    end

    // Stage 2: final result register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            err_p2  <= 1'b0;
            wrap_p2 <= 1'b0;
        end else if (adv_p1) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= res_p1;
                err_p2  <= err_p1;
                wrap_p2 <= wrap_p1;
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_data  = data_p2;
    assign bus.out_err   = err_p2;
    assign bus.out_wrap  = wrap_p2;
endmodule
